spi_master_engine: RTL and testbench

SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

---
 rtl/spi_master_engine_if.sv | 27 ++
 rtl/spi_master_engine.sv | 134 +++++++++++++
 tb/tb_spi_master_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_engine_if.sv
// rtl/spi_master_engine_if.sv - FIFO handshake and SPI pin bundle for spi_master_engine
interface spi_master_engine_if;
   logic       en;
   logic [1:0] freq;
   logic       tx_empty;
   logic       tx_rd;
   logic [8:0] din;
   logic       rx_full;
   logic       rx_wr;
   logic [7:0] dout;
   logic       transfer_succeeded;
   logic       busy;
   logic       cs;
   logic       sck;
   logic       mosi;
   logic       miso;

   modport master (
      input  en, freq, tx_empty, din, rx_full, miso,
      output tx_rd, rx_wr, dout, transfer_succeeded, busy, cs, sck, mosi
   );

   modport slave (
      output en, freq, tx_empty, din, rx_full, miso,
      input  tx_rd, rx_wr, dout, transfer_succeeded, busy, cs, sck, mosi
   );
endinterface

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - byte-oriented SPI mode-0 master fed by tx/rx FIFOs
module spi_master_engine #(
   parameter int DESEL_HP = 2
) (
   input  logic clk,
   input  logic rst,
   spi_master_engine_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, SHIFT, STORE, HOLD, DESEL} state_t;

   localparam logic [7:0] DESEL_LAST = 8'(DESEL_HP - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] shreg;
   logic       rx_bit;
   logic       cont;
   logic [1:0] div;
   logic [3:0] cnt;
   logic [7:0] hcnt;
   logic [3:0] hp_last;
   logic       tick;
   logic       cs_q;
   logic       sck_q;
   logic       mosi_q;
   logic [7:0] dout_q;

   // Half-period is 2^(div+1) clk cycles; tick marks its last cycle.
   always_comb begin
      case (div)
         2'd0:    hp_last = 4'd1;
         2'd1:    hp_last = 4'd3;
         2'd2:    hp_last = 4'd7;
         default: hp_last = 4'd15;
      endcase
   end

   assign tick = (cnt == hp_last);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (bus.en && !bus.tx_empty) state_next = FETCH;
         FETCH: begin
            if (bus.tx_empty) state_next = cs_q ? IDLE : HOLD;
            else              state_next = LOAD;
         end
         LOAD:  state_next = SETUP;
         SETUP: if (tick) state_next = SHIFT;
         SHIFT: if (tick && hcnt == 8'd15) state_next = STORE;
         STORE: begin
            if (!bus.rx_full) begin
               if (cont && bus.en) state_next = bus.tx_empty ? HOLD : FETCH;
               else                state_next = DESEL;
            end
         end
         HOLD: begin
            if (!bus.en)            state_next = DESEL;
            else if (!bus.tx_empty) state_next = FETCH;
         end
         DESEL: if (tick && hcnt == DESEL_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.tx_rd              = (state == FETCH) && !bus.tx_empty;
   assign bus.rx_wr              = (state == STORE) && !bus.rx_full;
   assign bus.transfer_succeeded = (state == STORE) && !bus.rx_full;
   assign bus.busy               = (state != IDLE);
   assign bus.cs                 = cs_q;
   assign bus.sck                = sck_q;
   assign bus.mosi               = mosi_q;
   assign bus.dout               = dout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         hcnt   <= '0;
         shreg  <= '0;
         rx_bit <= 1'b0;
         cont   <= 1'b0;
         div    <= '0;
         cs_q   <= 1'b1;
         sck_q  <= 1'b0;
         mosi_q <= 1'b0;
         dout_q <= '0;
      end else begin
         if (state_next != state || tick) cnt <= '0;
         else                             cnt <= cnt + 4'd1;

         if (state_next != state) hcnt <= '0;
         else if (tick)           hcnt <= hcnt + 8'd1;

         // cs only moves on frame boundaries, so it stays low across continued bytes.
         if (state_next == DESEL)      cs_q <= 1'b1;
         else if (state_next == SETUP) cs_q <= 1'b0;

         case (state)
            LOAD: begin
               shreg  <= bus.din[7:0];
               cont   <= bus.din[8];
               div    <= bus.freq;
               mosi_q <= bus.din[7];
            end
            SETUP: begin
               if (tick) begin
                  sck_q  <= 1'b1;
                  rx_bit <= bus.miso;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (hcnt == 8'd15) begin
                     dout_q <= shreg;
                  end else if (sck_q) begin
                     sck_q  <= 1'b0;
                     mosi_q <= shreg[6];
                     shreg  <= {shreg[6:0], rx_bit};
                  end else begin
                     sck_q  <= 1'b1;
                     rx_bit <= bus.miso;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_engine.sv
// tb/tb_spi_master_engine.sv - randomized self-checking bench for spi_master_engine
`timescale 1ns/1ps
module tb_spi_master_engine;
   localparam int DESEL_HP = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_master_engine_if bus();

   spi_master_engine #(.DESEL_HP(DESEL_HP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] tx_q[$];
   logic [7:0] exp_mosi[$];
   logic [7:0] exp_rx[$];
   logic [7:0] miso_q[$];
   int         got_frames[$];
   int         exp_frames[$];
   int         spans[$];
   int         exp_spans[$];

   int         cyc = 0;
   int         rise_cnt = 0;
   int         n_done = 0;
   int         n_rxwr = 0;
   int         bitpos = 0;
   int         frame_bytes = 0;
   int         cs_high = 0;
   int         t_first = 0;
   int         desel_min = 0;
   logic       loaded = 1'b0;
   logic       pop_pending = 1'b0;
   logic       sck_prev = 1'b0;
   logic       cs_prev = 1'b1;
   logic       skip_desel = 1'b1;
   logic [7:0] miso_byte = 8'h00;
   logic [7:0] mosi_acc = 8'h00;
   logic [7:0] last_dout = 8'h00;
   logic [7:0] last_mosi = 8'h00;
   logic [1:0] last_freq = 2'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // FIFO models, SPI slave and scoreboard all sample mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (cyc == 1) begin
         bus.din  = 9'h000;
         bus.miso = 1'b0;
      end
      if (pop_pending) begin
         pop_pending = 1'b0;
         check("tx_pop_nonempty", (tx_q.size() != 0), 1);
         if (tx_q.size() != 0) begin
            bus.din   = tx_q.pop_front();
            last_freq = bus.freq;
         end
      end
      if (bus.tx_rd) begin
         check("tx_rd_while_empty", bus.tx_empty, 0);
         pop_pending = 1'b1;
      end
      bus.tx_empty = (tx_q.size() == 0);

      if (bus.rx_wr) begin
         n_rxwr++;
         check("rx_wr_while_full", bus.rx_full, 0);
         check("ts_with_rx_wr", bus.transfer_succeeded, 1);
         check("rx_byte_expected", (exp_rx.size() != 0), 1);
         if (exp_rx.size() != 0) check("dout", bus.dout, exp_rx.pop_front());
         last_dout = bus.dout;
      end else if (bus.transfer_succeeded) begin
         check("ts_without_rx_wr", bus.transfer_succeeded, 0);
      end

      if (bus.sck && !sck_prev) check("sck_rise_needs_cs", bus.cs, 0);
      if (!bus.cs && bus.sck && !sck_prev) begin
         rise_cnt++;
         if (bitpos == 0) t_first = cyc;
         mosi_acc = {mosi_acc[6:0], bus.mosi};
         bitpos++;
         if (bitpos == 8) begin
            spans.push_back(cyc - t_first);
            last_mosi = mosi_acc;
            check("mosi_byte_expected", (exp_mosi.size() != 0), 1);
            if (exp_mosi.size() != 0) check("mosi_byte", mosi_acc, exp_mosi.pop_front());
            exp_rx.push_back(miso_byte);
            bitpos = 0;
            loaded = 1'b0;
            frame_bytes++;
            n_done++;
         end
      end

      if (bus.cs && !cs_prev) begin
         got_frames.push_back(frame_bytes);
         frame_bytes = 0;
         bitpos      = 0;
         loaded      = 1'b0;
         cs_high     = 0;
         desel_min   = DESEL_HP * (2 << last_freq);
      end
      if (!bus.cs && cs_prev) begin
         if (!skip_desel) check("desel_time", (cs_high >= desel_min), 1);
         skip_desel = 1'b0;
      end
      if (bus.cs) cs_high++;

      if (!bus.cs && !bus.sck && bitpos == 0 && !loaded) begin
         miso_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'($urandom);
         loaded    = 1'b1;
      end
      if (!bus.sck && loaded) bus.miso = miso_byte[7 - bitpos];

      sck_prev = bus.sck;
      cs_prev  = bus.cs;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [8:0] w);
      tx_q.push_back(w);
      exp_mosi.push_back(w[7:0]);
   endtask

   task automatic wait_idle(input string tag, input bit toggle_rx);
      int n;
      n = 0;
      step(); step(); step();
      while ((bus.busy || tx_q.size() != 0 || pop_pending) && n < 20000) begin
         if (toggle_rx) bus.rx_full = ($urandom_range(0, 3) == 0);
         step();
         n++;
      end
      bus.rx_full = 1'b0;
      check({tag, "_idle"}, bus.busy, 0);
   endtask

   task automatic wait_done(input string tag, input int target);
      int n;
      n = 0;
      while (n_done < target && n < 5000) begin
         step();
         n++;
      end
      check({tag, "_byte_done"}, n_done, target);
   endtask

   task automatic check_frames(input string tag);
      check({tag, "_frame_count"}, got_frames.size(), exp_frames.size());
      for (int i = 0; i < exp_frames.size(); i++)
         if (i < got_frames.size()) check({tag, "_frame_bytes"}, got_frames[i], exp_frames[i]);
      got_frames.delete();
      exp_frames.delete();
   endtask

   task automatic check_spans(input string tag);
      check({tag, "_span_count"}, spans.size(), exp_spans.size());
      for (int i = 0; i < exp_spans.size(); i++)
         if (i < spans.size()) check({tag, "_sck_span"}, spans[i], exp_spans[i]);
      spans.delete();
      exp_spans.delete();
   endtask

   initial begin
      int         r0;
      int         d0;
      int         c0;
      int         n;
      int         nw;
      int         run;
      logic [1:0] f;
      logic [8:0] w;

      bus.en      = 1'b0;
      bus.freq    = 2'd0;
      bus.rx_full = 1'b0;
      rst         = 1'b1;
      repeat (3) step();
      check("rst_cs", bus.cs, 1);
      check("rst_sck", bus.sck, 0);
      check("rst_mosi", bus.mosi, 0);
      check("rst_tx_rd", bus.tx_rd, 0);
      check("rst_rx_wr", bus.rx_wr, 0);
      check("rst_ts", bus.transfer_succeeded, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_dout", bus.dout, 0);
      rst    = 1'b0;
      bus.en = 1'b1;
      step();

      // single byte, loopback pattern A5
      r0 = n_rxwr;
      miso_q.push_back(8'hA5);
      push(9'h003);
      wait_idle("single", 1'b0);
      check("single_rx_wr_count", n_rxwr - r0, 1);
      check("single_dout", last_dout, 8'hA5);
      check("single_mosi", last_mosi, 8'h03);
      check("single_cs_high_after", (bus.cs == 1'b1 && cs_high >= 4), 1);
      exp_frames.push_back(1);
      check_frames("single");
      exp_spans.push_back(28);
      check_spans("single");

      // three continued bytes in one frame
      r0 = n_rxwr;
      push(9'h103); push(9'h1FF); push(9'h000);
      wait_idle("burst", 1'b0);
      check("burst_rx_wr_count", n_rxwr - r0, 3);
      exp_frames.push_back(3);
      check_frames("burst");
      repeat (3) exp_spans.push_back(28);
      check_spans("burst");

      // rx FIFO full stalls the engine in STORE
      bus.rx_full = 1'b1;
      r0 = n_rxwr;
      d0 = n_done;
      push(9'h05A);
      wait_done("stall", d0 + 1);
      repeat (20) step();
      check("stall_no_rx_wr", n_rxwr - r0, 0);
      check("stall_busy", bus.busy, 1);
      check("stall_sck", bus.sck, 0);
      check("stall_cs", bus.cs, 0);
      bus.rx_full = 1'b0;
      wait_idle("stall", 1'b0);
      check("stall_rx_wr_count", n_rxwr - r0, 1);
      exp_frames.push_back(1);
      check_frames("stall");
      exp_spans.push_back(28);
      check_spans("stall");

      // HOLD resumed by a late byte
      d0 = n_done;
      push(9'h1AB);
      wait_done("hold", d0 + 1);
      repeat (50) step();
      check("hold_busy", bus.busy, 1);
      check("hold_cs", bus.cs, 0);
      check("hold_sck", bus.sck, 0);
      push(9'h0CD);
      wait_idle("hold", 1'b0);
      exp_frames.push_back(2);
      check_frames("hold");
      exp_spans.push_back(28); exp_spans.push_back(28);
      check_spans("hold");

      // HOLD ended by dropping en
      d0 = n_done;
      push(9'h1AB);
      wait_done("hold_en", d0 + 1);
      repeat (50) step();
      check("hold_en_cs_low", bus.cs, 0);
      bus.en = 1'b0;
      wait_idle("hold_en", 1'b0);
      check("hold_en_cs_high", bus.cs, 1);
      exp_frames.push_back(1);
      check_frames("hold_en");
      exp_spans.push_back(28);
      check_spans("hold_en");
      bus.en = 1'b1;

      // reset in the middle of a slow byte
      bus.freq = 2'd3;
      r0 = n_rxwr;
      d0 = n_done;
      c0 = rise_cnt;
      push(9'h03C);
      n = 0;
      while (rise_cnt < c0 + 3 && n < 2000) begin
         step();
         n++;
      end
      check("rst_mid_rises", rise_cnt - c0, 3);
      skip_desel = 1'b1;
      rst = 1'b1;
      step();
      check("rst_mid_cs", bus.cs, 1);
      check("rst_mid_sck", bus.sck, 0);
      check("rst_mid_busy", bus.busy, 0);
      rst = 1'b0;
      void'(exp_mosi.pop_front());
      step(); step();
      check("rst_mid_no_rx_wr", n_rxwr - r0, 0);
      check("rst_mid_no_byte", n_done - d0, 0);
      got_frames.delete();
      push(9'h0E7);
      wait_idle("after_rst", 1'b0);
      check("after_rst_rx_wr", n_rxwr - r0, 1);
      exp_frames.push_back(1);
      check_frames("after_rst");
      exp_spans.push_back(7 * 32);
      check_spans("after_rst");

      // divider change mid-byte only affects the next byte
      bus.freq = 2'd0;
      c0 = rise_cnt;
      push(9'h15A); push(9'h0C3);
      n = 0;
      while (rise_cnt < c0 + 2 && n < 2000) begin
         step();
         n++;
      end
      bus.freq = 2'd2;
      wait_idle("freq_change", 1'b0);
      exp_frames.push_back(2);
      check_frames("freq_change");
      exp_spans.push_back(7 * 4); exp_spans.push_back(7 * 16);
      check_spans("freq_change");

      // random frames with random rx back-pressure
      for (int r = 0; r < 12; r++) begin
         f        = 2'($urandom_range(0, 3));
         nw       = $urandom_range(1, 4);
         run      = 0;
         bus.freq = f;
         r0       = n_rxwr;
         for (int i = 0; i < nw; i++) begin
            w = 9'($urandom);
            if (i == nw - 1) w[8] = 1'b0;
            push(w);
            run++;
            if (!w[8]) begin
               exp_frames.push_back(run);
               run = 0;
            end
            exp_spans.push_back(7 * (4 << f));
         end
         wait_idle("rand", 1'b1);
         check("rand_rx_wr_count", n_rxwr - r0, nw);
         check_frames("rand");
         check_spans("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
